// File: rtl/rca16_accumulator.sv
// Frame accumulator around a 16-bit XNOR-based ripple-carry adder.
// The adder's carry-out increments the accumulator's high part; wrap of the full accumulator sets a sticky flag.

module xnor_based_ripple_carry_adder16 (
  input  logic [15:0] add1_i,
  input  logic [15:0] add2_i,
  output logic [16:0] result_o
);

  logic [16:0] carry;
  logic [15:0] prop;

  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      // Double XNOR gives the three-input XOR of a full adder.
      assign prop[i]        = add1_i[i] ^ add2_i[i];
      assign result_o[i]    = ~((~(add1_i[i] ^ add2_i[i])) ^ carry[i]);
      assign carry[i+1]     = (add1_i[i] & add2_i[i]) | (carry[i] & prop[i]);
    end
  endgenerate

  assign result_o[16] = carry[16];

endmodule

// state  | meaning
// IDLE   | waiting for start_i; outputs hold the last frame result
// ACCUM  | accepting words until the word count runs out
// DONE   | one-cycle done pulse, sum_o final
module rca16_accumulator #(
  parameter int ACC_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       len_i,
  input  logic [15:0]      data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int HI_W = ACC_W - 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             ovf_evt;
  logic [7:0]       cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [16:0]      add_res;
  logic [HI_W-1:0]  acc_hi;

  xnor_based_ripple_carry_adder16 u_adder (
    .add1_i   (acc_q[15:0]),
    .add2_i   (data_i),
    .result_o (add_res)
  );

  assign acc_hi  = acc_q[ACC_W-1:16];
  assign acc_d   = {acc_hi + HI_W'(add_res[16]), add_res[15:0]};
  assign ovf_evt = add_res[16] & (&acc_hi);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len_i != 8'd0) begin
              cnt_q   <= len_i;
              ready_q <= 1'b1;
              state_q <= ACCUM;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ACCUM: begin
          if (valid_i && ready_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | ovf_evt;
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = acc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_rca16_accumulator.sv
// Randomized self-checking bench for rca16_accumulator; the reference is the running
// arithmetic total of each frame, reduced modulo 2^ACC_W, with overflow when the total reaches 2^ACC_W.

module tb_rca16_accumulator;

  localparam int ACC_W = 17;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [7:0]       len_i;
  logic [15:0]      data_i;
  logic             valid_i;
  logic             ready_o;
  logic             busy_o;
  logic [ACC_W-1:0] sum_o;
  logic             ovf_o;
  logic             done_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] words [256];
  logic [ACC_W+3:0] obs;
  logic [ACC_W+3:0] exp_v;

  rca16_accumulator #(.ACC_W(ACC_W)) u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .len_i   (len_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .sum_o   (sum_o),
    .ovf_o   (ovf_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
    obs = {ready_o, busy_o, done_o, ovf_o, sum_o};
  endtask

  // Runs one frame of words[0..len-1] with random valid gaps, checking every cycle.
  task automatic do_frame(input int len, input int gmin, input int gmax, input bit poke);
    longint total = 0;
    logic [ACC_W-1:0] sum_m = '0;
    logic ovf_m = 1'b0;
    bit last;
    start_i = 1'b1;
    len_i   = 8'(len);
    valid_i = 1'b0;
    step();
    start_i = 1'b0;
    len_i   = 8'($urandom);
    if (len == 0) exp_v = {1'b0, 1'b1, 1'b1, 1'b0, {ACC_W{1'b0}}};
    else          exp_v = {1'b1, 1'b1, 1'b0, 1'b0, {ACC_W{1'b0}}};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL frame_start len=%0d got %h expected %h", len, obs, exp_v);
    end
    for (int i = 0; i < len; i++) begin
      int gaps = $urandom_range(gmax, gmin);
      for (int g = 0; g < gaps; g++) begin
        valid_i = 1'b0;
        data_i  = 16'($urandom);
        if (poke) begin
          start_i = 1'b1;
          len_i   = 8'($urandom);
        end
        step();
        start_i = 1'b0;
        exp_v = {1'b1, 1'b1, 1'b0, ovf_m, sum_m};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL gap_hold word=%0d got %h expected %h", i, obs, exp_v);
        end
      end
      valid_i = 1'b1;
      data_i  = words[i];
      step();
      valid_i = 1'b0;
      data_i  = 16'($urandom);
      total += longint'(words[i]);
      sum_m = ACC_W'(total);
      ovf_m = (total >= (64'sd1 << ACC_W));
      last  = (i == len - 1);
      exp_v = {~last, 1'b1, last, ovf_m, sum_m};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL accept word=%0d got %h expected %h", i, obs, exp_v);
      end
    end
    // A start during the done cycle must not launch a frame.
    if (poke) begin
      start_i = 1'b1;
      len_i   = 8'($urandom_range(255, 1));
    end
    step();
    start_i = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b0, ovf_m, sum_m};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_after_done len=%0d got %h expected %h", len, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    start_i = 1'b1; len_i = 8'd10; valid_i = 1'b0; data_i = '0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = 16'($urandom);
      step();
    end
    rst_i = 1'b1;
    step();
    step();
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", obs, exp_v);
    end
    rst_i = 1'b0; valid_i = 1'b1; data_i = 16'hABCD;
    step();
    valid_i = 1'b0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_idle_ignores_data got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_basic();
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    do_frame(3, 0, 0, 1'b0);
    checks++;
    if (sum_o !== 17'h00006 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got %h/%b expected 00006/0", sum_o, ovf_o);
    end
  endtask

  task automatic test_carry();
    words[0] = 16'hFFFF; words[1] = 16'h0001;
    do_frame(2, 0, 0, 1'b0);
    checks++;
    if (sum_o !== 17'h10000 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL carry_sum got %h/%b expected 10000/0", sum_o, ovf_o);
    end
  endtask

  task automatic test_overflow();
    words[0] = 16'hFFFF; words[1] = 16'hFFFF; words[2] = 16'hFFFF;
    do_frame(3, 0, 0, 1'b0);
    checks++;
    if (sum_o !== 17'h0FFFD || ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sum got %h/%b expected 0fffd/1", sum_o, ovf_o);
    end
    words[0] = 16'h0005;
    do_frame(1, 0, 0, 1'b0);
    checks++;
    if (sum_o !== 17'h00005 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got %h/%b expected 00005/0", sum_o, ovf_o);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    do_frame(0, 0, 0, 1'b0);
    words[0] = 16'($urandom); words[1] = 16'($urandom);
    do_frame(2, 3, 3, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    start_i = 1'b1; len_i = 8'd4;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; data_i = 16'($urandom);
      step();
    end
    rst_i = 1'b1; valid_i = 1'b1;
    step();
    rst_i = 1'b0; valid_i = 1'b0;
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_frame got %h expected %h", obs, exp_v);
    end
    words[0] = 16'h1234;
    do_frame(1, 0, 0, 1'b0);
    checks++;
    if (sum_o !== 17'h01234 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_sum got %h/%b expected 01234/0", sum_o, ovf_o);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) words[i] = 16'($urandom);
      do_frame(len, 0, 2, f[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 255; i++) words[i] = 16'hFFFF;
    do_frame(255, 0, 0, 1'b0);
    for (int i = 0; i < 255; i++) words[i] = 16'($urandom_range(16'hFFFF, 16'hF000));
    do_frame(255, 0, 0, 1'b1);
    words[0] = 16'h7777;
    do_frame(1, 0, 0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; data_i = '0; valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_zero_and_ignored_start();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
